// File: rtl/dadda_mac_acc_8.sv
// Purpose : streaming 8x8 unsigned multiply-accumulate; sums N_TERMS Dadda/CSA products per output block.
// Latency : last pair of a block accepted in cycle t -> out_valid visible in cycle t+3.
// Backpr. : in_ready drops once a block's N_TERMS pairs are accepted; out_sum is held until out_ready.
//
// Ports:
//   clk, rst              rising-edge clock, synchronous active-high reset
//   in_valid/in_ready     operand pair handshake, in_a/in_b unsigned 8-bit operands
//   out_valid/out_ready   block result handshake, out_sum = sum of N_TERMS products
//   busy                  a block has started (first pair accepted) and is not yet delivered
module dadda_mac_acc_8 #(
    parameter int N_TERMS = 8,
    parameter int ACC_W   = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_a,
    input  logic [7:0]       in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic             busy
);

    // Counters must be able to hold the value N_TERMS itself.
    localparam int CNT_W = $clog2(N_TERMS + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_TERMS);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ACC   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_t;

    // 3:2 carry-save compressor on 16-bit rows: returns {carry_row, sum_row}.
    // Bits carried out of bit 15 are dropped; the full product fits in 16 bits,
    // so every row sum stays exact modulo 2^16.
    function automatic logic [31:0] csa3(input logic [15:0] x, input logic [15:0] y,
                                         input logic [15:0] z);
        logic [15:0] s;
        logic [15:0] m;
        s = x ^ y ^ z;
        m = (x & y) | (x & z) | (y & z);
        return {m[14:0], 1'b0, s};
    endfunction

    // 8x8 unsigned multiplier. Eight partial-product rows are reduced with
    // carry-save stages following the Dadda height sequence 8 -> 6 -> 4 -> 3 -> 2,
    // then a single carry-propagate add produces the product.
    function automatic logic [15:0] dadda_mult_CSA_8(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] pp [8];
        logic [31:0] r1, r2, r3, r4, r5, r6;
        for (int i = 0; i < 8; i++) begin
            pp[i] = {8'd0, a & {8{b[i]}}} << i;
        end
        // 8 rows -> 6 rows
        r1 = csa3(pp[0], pp[1], pp[2]);
        r2 = csa3(pp[3], pp[4], pp[5]);
        // 6 rows -> 4 rows
        r3 = csa3(r1[15:0], r1[31:16], r2[15:0]);
        r4 = csa3(r2[31:16], pp[6], pp[7]);
        // 4 rows -> 3 rows
        r5 = csa3(r3[15:0], r3[31:16], r4[15:0]);
        // 3 rows -> 2 rows
        r6 = csa3(r5[15:0], r5[31:16], r4[31:16]);
        return r6[15:0] + r6[31:16];
    endfunction

    state_t             state_q,    state_d;
    logic [7:0]         a_q,        a_d;
    logic [7:0]         b_q,        b_d;
    logic               v0_q,       v0_d;
    logic [15:0]        p_q,        p_d;
    logic               v1_q,       v1_d;
    logic [ACC_W-1:0]   acc_q,      acc_d;
    logic [CNT_W-1:0]   acc_cnt_q,  acc_cnt_d;
    logic [CNT_W-1:0]   done_cnt_q, done_cnt_d;
    logic               accept;
    logic               out_fire;

    always_comb begin
        // Outputs are forced idle while reset is asserted, even before the
        // reset edge has cleared the state register.
        in_ready  = ~rst & (state_q == ACC);
        out_valid = ~rst & (state_q == DONE);
        out_sum   = rst ? '0 : acc_q;
        busy      = ~rst & ((state_q != ACC) | (acc_cnt_q != '0));
        accept    = in_valid & in_ready;
        out_fire  = out_valid & out_ready;

        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        v0_d       = accept;
        p_d        = dadda_mult_CSA_8(a_q, b_q);
        v1_d       = v0_q;
        acc_d      = acc_q;
        acc_cnt_d  = acc_cnt_q;
        done_cnt_d = done_cnt_q;

        // P0 capture
        if (accept) begin
            a_d = in_a;
            b_d = in_b;
        end

        // P2 accumulate; runs in any state because products of a block may
        // still be in flight after the FSM has left ACC.
        if (v1_q) begin
            acc_d      = acc_q + ACC_W'(p_q);
            done_cnt_d = done_cnt_q + CNT_ONE;
        end

        case (state_q)
            ACC: begin
                if (accept) begin
                    acc_cnt_d = acc_cnt_q + CNT_ONE;
                    if (acc_cnt_d == LAST_CNT) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (v1_q && (done_cnt_d == LAST_CNT)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_fire) begin
                    acc_d      = '0;
                    acc_cnt_d  = '0;
                    done_cnt_d = '0;
                    state_d    = ACC;
                end
            end
            default: begin
                state_d = ACC;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ACC;
            a_q        <= '0;
            b_q        <= '0;
            v0_q       <= 1'b0;
            p_q        <= '0;
            v1_q       <= 1'b0;
            acc_q      <= '0;
            acc_cnt_q  <= '0;
            done_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            v0_q       <= v0_d;
            p_q        <= p_d;
            v1_q       <= v1_d;
            acc_q      <= acc_d;
            acc_cnt_q  <= acc_cnt_d;
            done_cnt_q <= done_cnt_d;
        end
    end

endmodule

// File: tb/tb_dadda_mac_acc_8.sv
// Purpose : self-checking bench for dadda_mac_acc_8 (N_TERMS=8, ACC_W=24).
// Latency : drives on the falling edge, samples on the falling edge, expects results 3 cycles after the last accept.
// Backpr. : exercises held outputs under out_ready=0 and ignored in_valid while in_ready=0.
module tb_dadda_mac_acc_8;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_a;
    logic [7:0]  in_b;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] out_sum;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;
    int stall_cnt;

    always #5 clk = ~clk;

    dadda_mac_acc_8 #(.N_TERMS(8), .ACC_W(24)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .busy      (busy)
    );

    typedef struct {
        string            name;
        logic [7:0][7:0]  a;
        logic [7:0][7:0]  b;
        int               gap;
        logic [23:0]      exp_sum;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Called just after a falling edge; returns just after the falling edge
    // that follows the accepting rising edge.
    task automatic send_pair(input logic [7:0] a, input logic [7:0] b);
        int w;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        w        = 0;
        while (in_ready !== 1'b1 && w <= 100) begin
            @(negedge clk);
            w++;
            stall_cnt++;
        end
        if (w > 100) check("accept_timeout", 32'd1, 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            if (in_ready !== 1'b1) stall_cnt++;
        end
    endtask

    task automatic run_block(input string name, input logic [7:0][7:0] a, input logic [7:0][7:0] b,
                             input int gap, input logic [23:0] exp, input int hold);
        int n;
        stall_cnt = 0;
        out_ready = (hold == 0);
        for (int j = 0; j < 8; j++) begin
            send_pair(a[j], b[j]);
            if (j == 0) check({name, "_busy_start"}, busy, 1);
            if (j < 7) idle(gap);
        end
        check({name, "_stall"}, stall_cnt, 0);
        n = 0;
        while (out_valid !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({name, "_latency"}, n, 2);
        check({name, "_sum"}, out_sum, exp);
        if (hold > 0) begin
            // Offered pairs during the hold must be ignored.
            in_valid = 1'b1;
            in_a     = 8'd99;
            in_b     = 8'd99;
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                check({name, "_hold_valid"}, out_valid, 1);
                check({name, "_hold_sum"}, out_sum, exp);
                check({name, "_hold_in_ready"}, in_ready, 0);
            end
            out_ready = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        check({name, "_valid_drop"}, out_valid, 0);
        check({name, "_ready_back"}, in_ready, 1);
        check({name, "_busy_end"}, busy, 0);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          exp_q [$];
        int          got;
        int          sent;
        int          cnt;
        int          run_sum;
        int          dcyc;
        int          scyc;
        logic        r;

        vecs[0].name = "max255";  vecs[0].gap = 0; vecs[0].exp_sum = 24'd520200;
        vecs[1].name = "k_sq";    vecs[1].gap = 1; vecs[1].exp_sum = 24'd204;
        vecs[2].name = "zeros";   vecs[2].gap = 0; vecs[2].exp_sum = 24'd0;
        vecs[3].name = "three5";  vecs[3].gap = 0; vecs[3].exp_sum = 24'd120;
        vecs[4].name = "ff_by_k"; vecs[4].gap = 0; vecs[4].exp_sum = 24'd9180;
        vecs[5].name = "k_by_9k"; vecs[5].gap = 2; vecs[5].exp_sum = 24'd120;
        for (int j = 0; j < 8; j++) begin
            vecs[0].a[j] = 8'd255;     vecs[0].b[j] = 8'd255;
            vecs[1].a[j] = 8'(j + 1);  vecs[1].b[j] = 8'(j + 1);
            vecs[2].a[j] = 8'd0;       vecs[2].b[j] = 8'd0;
            vecs[3].a[j] = 8'd3;       vecs[3].b[j] = 8'd5;
            vecs[4].a[j] = 8'd255;     vecs[4].b[j] = 8'(j + 1);
            vecs[5].a[j] = 8'(j + 1);  vecs[5].b[j] = 8'(8 - j);
        end

        // Reset state
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_a      = 8'd0;
        in_b      = 8'd0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_sum", out_sum, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", in_ready, 1);
        check("post_rst_out_valid", out_valid, 0);
        check("post_rst_busy", busy, 0);

        // Held output under backpressure, ignored pairs during the hold
        run_block("hold16", {8{8'd16}}, {8{8'd16}}, 0, 24'd2048, 5);

        // Directed block table
        for (int i = 0; i < 6; i++) begin
            run_block(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].gap, vecs[i].exp_sum, 0);
        end

        // Reset in the middle of a block discards the partial sum
        send_pair(8'd200, 8'd100);
        send_pair(8'd200, 8'd100);
        send_pair(8'd200, 8'd100);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_in_ready", in_ready, 0);
        check("midrst_out_sum", out_sum, 0);
        rst = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        run_block("after_rst", {8{8'd1}}, {8{8'd2}}, 0, 24'd16, 0);

        // Random operands with random in_valid / out_ready
        got     = 0;
        sent    = 0;
        cnt     = 0;
        run_sum = 0;
        @(negedge clk);
        fork
            begin
                dcyc = 0;
                while (sent < 24 && dcyc < 3000) begin
                    if (in_ready === 1'b1 && $urandom_range(0, 3) != 0) begin
                        in_valid = 1'b1;
                        in_a     = 8'($urandom);
                        in_b     = 8'($urandom);
                        run_sum  = run_sum + int'(in_a) * int'(in_b);
                        cnt++;
                        sent++;
                        if (cnt == 8) begin
                            exp_q.push_back(run_sum);
                            run_sum = 0;
                            cnt     = 0;
                        end
                    end else if (in_ready === 1'b1) begin
                        in_valid = 1'b0;
                    end else begin
                        in_valid = 1'($urandom_range(0, 1));
                        in_a     = 8'($urandom);
                        in_b     = 8'($urandom);
                    end
                    @(negedge clk);
                    dcyc++;
                end
                in_valid = 1'b0;
            end
            begin
                scyc = 0;
                while (got < 3 && scyc < 3000) begin
                    @(negedge clk);
                    scyc++;
                    r         = 1'($urandom_range(0, 1));
                    out_ready = r;
                    if (out_valid === 1'b1 && r) begin
                        if (exp_q.size() == 0) check("rand_unexpected_out", 1, 0);
                        else check("rand_sum", out_sum, exp_q.pop_front());
                        got++;
                    end
                end
                check("rand_blocks", got, 3);
            end
        join
        @(negedge clk);
        out_ready = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
